// File: rtl/ysyx_22050499_scoreboard.sv
// Register-write scoreboard with RAW interlock: per-register pending-write counters
// for GPRs and the CSR file. Define YSYX_22050499_SB_BYPASS_EN to release on WB forward.
module ysyx_22050499_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       id_valid,
  input  logic       id_fire,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] id_rd,
  input  logic       id_rd_wen,
  input  logic       id_csr_ren,
  input  logic       id_csr_wen,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       wb_rd_wen,
  input  logic       wb_csr_wen,
  input  logic       flush,
  output logic       stall,
  output logic       sb_idle,
  output logic       sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] gpr_cnt_q [1:31];
  logic [CNT_W-1:0] gpr_cnt_d [1:31];
  logic [CNT_W-1:0] csr_cnt_q, csr_cnt_d;
  logic             sb_idle_q, sb_idle_d;
  logic             sb_err_q, sb_err_d;

  logic        inc_gpr, dec_gpr, inc_csr, dec_csr;
  logic [31:0] inc_hit, dec_hit;
  logic [31:0] gpr_busy;
  logic        csr_busy;

  assign inc_gpr = id_fire & id_rd_wen & (id_rd != 5'd0);
  assign dec_gpr = wb_valid & wb_rd_wen & (wb_rd != 5'd0);
  assign inc_csr = id_fire & id_csr_wen;
  assign dec_csr = wb_valid & wb_csr_wen;

  assign inc_hit = inc_gpr ? (32'd1 << id_rd) : 32'd0;
  assign dec_hit = dec_gpr ? (32'd1 << wb_rd) : 32'd0;

  // Busy uses register state only; with bypass, a last pending writer committing now is forwarded.
  always_comb begin
    gpr_busy = 32'd0;
    for (int r = 1; r < 32; r++) begin
      gpr_busy[r] = (gpr_cnt_q[r] != '0);
`ifdef YSYX_22050499_SB_BYPASS_EN
      if ((gpr_cnt_q[r] == CNT_ONE) && dec_hit[r]) gpr_busy[r] = 1'b0;
`endif
    end
    csr_busy = (csr_cnt_q != '0);
`ifdef YSYX_22050499_SB_BYPASS_EN
    if ((csr_cnt_q == CNT_ONE) && dec_csr) csr_busy = 1'b0;
`endif
  end

  // stall deliberately ignores id_fire so issue logic may depend on it without a loop.
  assign stall = id_valid & ((id_rs1_used & gpr_busy[id_rs1]) |
                             (id_rs2_used & gpr_busy[id_rs2]) |
                             (id_csr_ren & csr_busy));

  always_comb begin
    sb_err_d  = sb_err_q;
    csr_cnt_d = csr_cnt_q;
    for (int r = 1; r < 32; r++) begin
      gpr_cnt_d[r] = gpr_cnt_q[r];
      if (flush) begin
        gpr_cnt_d[r] = '0;
      end else if (inc_hit[r] && !dec_hit[r]) begin
        if (gpr_cnt_q[r] == CNT_MAX) sb_err_d = 1'b1;
        else                         gpr_cnt_d[r] = gpr_cnt_q[r] + CNT_ONE;
      end else if (dec_hit[r] && !inc_hit[r]) begin
        if (gpr_cnt_q[r] == '0) sb_err_d = 1'b1;
        else                    gpr_cnt_d[r] = gpr_cnt_q[r] - CNT_ONE;
      end
    end

    if (flush) begin
      csr_cnt_d = '0;
    end else if (inc_csr && !dec_csr) begin
      if (csr_cnt_q == CNT_MAX) sb_err_d = 1'b1;
      else                      csr_cnt_d = csr_cnt_q + CNT_ONE;
    end else if (dec_csr && !inc_csr) begin
      if (csr_cnt_q == '0) sb_err_d = 1'b1;
      else                 csr_cnt_d = csr_cnt_q - CNT_ONE;
    end

    // Issuing past an interlock is a protocol error even though the write is still tracked.
    if (id_fire && stall) sb_err_d = 1'b1;

    sb_idle_d = (csr_cnt_d == '0);
    for (int r = 1; r < 32; r++) begin
      if (gpr_cnt_d[r] != '0) sb_idle_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 1; r < 32; r++) gpr_cnt_q[r] <= '0;
      csr_cnt_q <= '0;
      sb_idle_q <= 1'b1;
      sb_err_q  <= 1'b0;
    end else begin
      for (int r = 1; r < 32; r++) gpr_cnt_q[r] <= gpr_cnt_d[r];
      csr_cnt_q <= csr_cnt_d;
      sb_idle_q <= sb_idle_d;
      sb_err_q  <= sb_err_d;
    end
  end

  assign sb_idle = sb_idle_q;
  assign sb_err  = sb_err_q;

endmodule

// File: tb/tb_ysyx_22050499_scoreboard.sv
// Directed bench for ysyx_22050499_scoreboard: inputs change just after the falling
// edge, outputs are sampled 1ns later, well away from the rising edge.
module tb_ysyx_22050499_scoreboard;

`ifdef YSYX_22050499_SB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic       clock, reset;
  logic       id_valid, id_fire, id_rs1_used, id_rs2_used, id_rd_wen;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic       id_csr_ren, id_csr_wen, wb_valid, wb_rd_wen, wb_csr_wen, flush;
  logic       stall, sb_idle, sb_err;
  int         n_cmp, n_mis;

  ysyx_22050499_scoreboard #(.CNT_W(2)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_fire(id_fire),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_wen(id_rd_wen),
    .id_csr_ren(id_csr_ren), .id_csr_wen(id_csr_wen),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_rd_wen(wb_rd_wen), .wb_csr_wen(wb_csr_wen),
    .flush(flush), .stall(stall), .sb_idle(sb_idle), .sb_err(sb_err)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clr();
    id_valid = 0; id_fire = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_wen = 0; id_csr_ren = 0; id_csr_wen = 0;
    wb_valid = 0; wb_rd = 0; wb_rd_wen = 0; wb_csr_wen = 0; flush = 0;
  endtask

  // Advance to the next falling edge with idle inputs.
  task automatic nxt();
    @(negedge clock);
    clr();
  endtask

  task automatic do_reset();
    @(negedge clock);
    clr();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // driver helpers (set fields on top of clr())
  task automatic issue_rd(input logic [4:0] rd);
    id_valid = 1; id_fire = 1; id_rd = rd; id_rd_wen = 1;
  endtask

  task automatic commit_rd(input logic [4:0] rd);
    wb_valid = 1; wb_rd = rd; wb_rd_wen = 1;
  endtask

  task automatic read_rs1(input logic [4:0] rs);
    id_valid = 1; id_rs1 = rs; id_rs1_used = 1;
  endtask

  task automatic test_reset();
    do_reset();
    read_rs1(5'd5);
    #1;
    n_cmp++; if (stall !== 1'b0)   begin n_mis++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (sb_idle !== 1'b1) begin n_mis++; $display("FAIL reset_idle: got %b want 1", sb_idle); end
    n_cmp++; if (sb_err !== 1'b0)  begin n_mis++; $display("FAIL reset_err: got %b want 0", sb_err); end
  endtask

  task automatic test_raw();
    nxt(); issue_rd(5'd5); #1;
    n_cmp++; if (stall !== 1'b0)   begin n_mis++; $display("FAIL raw_issue_stall: got %b want 0", stall); end
    nxt(); read_rs1(5'd5); #1;
    n_cmp++; if (stall !== 1'b1)   begin n_mis++; $display("FAIL raw_busy_c2: got %b want 1", stall); end
    n_cmp++; if (sb_idle !== 1'b0) begin n_mis++; $display("FAIL raw_idle_c2: got %b want 0", sb_idle); end
    nxt(); read_rs1(5'd5); #1;
    n_cmp++; if (stall !== 1'b1)   begin n_mis++; $display("FAIL raw_busy_c3: got %b want 1", stall); end
    nxt(); read_rs1(5'd5); commit_rd(5'd5); #1;
    n_cmp++; if (stall !== !BYP)   begin n_mis++; $display("FAIL raw_commit_cycle: got %b want %b", stall, !BYP); end
    nxt(); read_rs1(5'd5); #1;
    n_cmp++; if (stall !== 1'b0)   begin n_mis++; $display("FAIL raw_released: got %b want 0", stall); end
    n_cmp++; if (sb_idle !== 1'b1) begin n_mis++; $display("FAIL raw_idle_end: got %b want 1", sb_idle); end
  endtask

  task automatic test_multi_writer();
    nxt(); issue_rd(5'd7);
    nxt(); issue_rd(5'd7);
    nxt(); read_rs1(5'd7); commit_rd(5'd7); #1;
    n_cmp++; if (stall !== 1'b1)   begin n_mis++; $display("FAIL multi_cnt2_commit: got %b want 1", stall); end
    nxt(); read_rs1(5'd7); #1;
    n_cmp++; if (stall !== 1'b1)   begin n_mis++; $display("FAIL multi_cnt1_busy: got %b want 1", stall); end
    n_cmp++; if (sb_idle !== 1'b0) begin n_mis++; $display("FAIL multi_cnt1_idle: got %b want 0", sb_idle); end
    nxt(); read_rs1(5'd7); commit_rd(5'd7); #1;
    n_cmp++; if (stall !== !BYP)   begin n_mis++; $display("FAIL multi_last_commit: got %b want %b", stall, !BYP); end
    nxt(); read_rs1(5'd7); #1;
    n_cmp++; if (stall !== 1'b0)   begin n_mis++; $display("FAIL multi_drained: got %b want 0", stall); end
    n_cmp++; if (sb_idle !== 1'b1) begin n_mis++; $display("FAIL multi_idle: got %b want 1", sb_idle); end
  endtask

  task automatic test_same_cycle_and_x0();
    nxt(); issue_rd(5'd3);
    nxt(); issue_rd(5'd3); commit_rd(5'd3);
    nxt(); id_valid = 1; id_rs2 = 5'd3; id_rs2_used = 1; #1;
    n_cmp++; if (stall !== 1'b1)   begin n_mis++; $display("FAIL same_cycle_rs2: got %b want 1", stall); end
    n_cmp++; if (sb_err !== 1'b0)  begin n_mis++; $display("FAIL same_cycle_err: got %b want 0", sb_err); end
    nxt(); issue_rd(5'd0); id_rs1 = 5'd0; id_rs1_used = 1; id_rs2 = 5'd0; id_rs2_used = 1; #1;
    n_cmp++; if (stall !== 1'b0)   begin n_mis++; $display("FAIL x0_read: got %b want 0", stall); end
    nxt(); commit_rd(5'd3);
    nxt(); commit_rd(5'd0);
    nxt(); #1;
    n_cmp++; if (sb_idle !== 1'b1) begin n_mis++; $display("FAIL x0_not_counted: got %b want 1", sb_idle); end
    n_cmp++; if (sb_err !== 1'b0)  begin n_mis++; $display("FAIL x0_no_underflow: got %b want 0", sb_err); end
  endtask

  task automatic test_csr();
    nxt(); id_valid = 1; id_fire = 1; id_csr_wen = 1;
    nxt(); id_csr_ren = 1; #1;
    n_cmp++; if (stall !== 1'b0)   begin n_mis++; $display("FAIL csr_no_valid: got %b want 0", stall); end
    id_valid = 1; #1;
    n_cmp++; if (stall !== 1'b1)   begin n_mis++; $display("FAIL csr_busy: got %b want 1", stall); end
    nxt(); id_valid = 1; id_csr_ren = 1; wb_valid = 1; wb_csr_wen = 1; #1;
    n_cmp++; if (stall !== !BYP)   begin n_mis++; $display("FAIL csr_commit_cycle: got %b want %b", stall, !BYP); end
    nxt(); id_valid = 1; id_csr_ren = 1; #1;
    n_cmp++; if (stall !== 1'b0)   begin n_mis++; $display("FAIL csr_released: got %b want 0", stall); end
    n_cmp++; if (sb_idle !== 1'b1) begin n_mis++; $display("FAIL csr_idle: got %b want 1", sb_idle); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue_rd(5'd9);
      nxt();
    end
    #1;
    n_cmp++; if (sb_err !== 1'b0)  begin n_mis++; $display("FAIL ovf_at_max: got %b want 0", sb_err); end
    issue_rd(5'd9);
    nxt(); #1;
    n_cmp++; if (sb_err !== 1'b1)  begin n_mis++; $display("FAIL ovf_err: got %b want 1", sb_err); end
    commit_rd(5'd9);
    nxt(); commit_rd(5'd9);
    nxt(); read_rs1(5'd9); #1;
    n_cmp++; if (stall !== 1'b1)   begin n_mis++; $display("FAIL ovf_saturated_3: got %b want 1", stall); end
    nxt(); commit_rd(5'd9);
    nxt(); read_rs1(5'd9); #1;
    n_cmp++; if (stall !== 1'b0)   begin n_mis++; $display("FAIL ovf_drained: got %b want 0", stall); end
    n_cmp++; if (sb_idle !== 1'b1) begin n_mis++; $display("FAIL ovf_idle: got %b want 1", sb_idle); end
    n_cmp++; if (sb_err !== 1'b1)  begin n_mis++; $display("FAIL ovf_sticky: got %b want 1", sb_err); end
  endtask

  task automatic test_underflow();
    do_reset(); #1;
    n_cmp++; if (sb_err !== 1'b0)  begin n_mis++; $display("FAIL udf_reset_clear: got %b want 0", sb_err); end
    commit_rd(5'd9);
    nxt(); #1;
    n_cmp++; if (sb_err !== 1'b1)  begin n_mis++; $display("FAIL udf_err: got %b want 1", sb_err); end
    n_cmp++; if (sb_idle !== 1'b1) begin n_mis++; $display("FAIL udf_idle: got %b want 1", sb_idle); end
  endtask

  task automatic test_flush();
    do_reset();
    issue_rd(5'd4); id_csr_wen = 1;
    nxt(); #1;
    n_cmp++; if (sb_idle !== 1'b0) begin n_mis++; $display("FAIL flush_pre_idle: got %b want 0", sb_idle); end
    flush = 1; issue_rd(5'd8);
    nxt(); read_rs1(5'd4); id_rs2 = 5'd8; id_rs2_used = 1; id_csr_ren = 1; #1;
    n_cmp++; if (stall !== 1'b0)   begin n_mis++; $display("FAIL flush_stall: got %b want 0", stall); end
    n_cmp++; if (sb_idle !== 1'b1) begin n_mis++; $display("FAIL flush_idle: got %b want 1", sb_idle); end
    n_cmp++; if (sb_err !== 1'b0)  begin n_mis++; $display("FAIL flush_err: got %b want 0", sb_err); end
  endtask

  task automatic test_fire_while_stall();
    do_reset();
    issue_rd(5'd10);
    nxt(); read_rs1(5'd10); id_fire = 1; id_rd = 5'd11; id_rd_wen = 1; #1;
    n_cmp++; if (stall !== 1'b1)   begin n_mis++; $display("FAIL fws_stall: got %b want 1", stall); end
    nxt(); read_rs1(5'd11); #1;
    n_cmp++; if (sb_err !== 1'b1)  begin n_mis++; $display("FAIL fws_err: got %b want 1", sb_err); end
    n_cmp++; if (stall !== 1'b1)   begin n_mis++; $display("FAIL fws_counted: got %b want 1", stall); end
  endtask

  task automatic test_reset_mid_op();
    flush = 1; reset = 1'b1;
    @(negedge clock);
    clr(); reset = 1'b0; read_rs1(5'd10); #1;
    n_cmp++; if (stall !== 1'b0)   begin n_mis++; $display("FAIL rst_mid_stall: got %b want 0", stall); end
    n_cmp++; if (sb_idle !== 1'b1) begin n_mis++; $display("FAIL rst_mid_idle: got %b want 1", sb_idle); end
    n_cmp++; if (sb_err !== 1'b0)  begin n_mis++; $display("FAIL rst_mid_err: got %b want 0", sb_err); end
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    reset = 1'b1;
    clr();
    test_reset();
    test_raw();
    test_multi_writer();
    test_same_cycle_and_x0();
    test_csr();
    test_overflow();
    test_underflow();
    test_flush();
    test_fire_while_stall();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ysyx_22050499_scoreboard.md
# ysyx_22050499_scoreboard

Register-write scoreboard and RAW-hazard interlock for the in-order pipeline. It tracks outstanding writes to the GPRs and the CSR file from issue in ID until the write-back stage commits them. It raises a combinational stall to ID whenever the instruction waiting there reads a register with a pending write. It sits beside the ID stage and is cleared by the write-back stage's commit signals.

## Interface
- Parameters:
- CNT_W, 2, width of each per-register pending-write counter (max in-flight writers per register = 2^CNT_W − 1)
- Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a valid instruction
- id_fire  in  1  instruction leaves ID this cycle (issue)
- id_rs1, id_rs2  in  5 each  source register indices
- id_rs1_used, id_rs2_used  in  1 each  source actually read
- id_rd  in  5  destination index
- id_rd_wen  in  1  instruction writes a GPR
- id_csr_ren, id_csr_wen  in  1 each  instruction reads / writes a CSR
- wb_valid  in  1  WB commits an instruction this cycle
- wb_rd  in  5  WB destination index
- wb_rd_wen, wb_csr_wen  in  1 each  WB write enables
- flush  in  1  kill all in-flight instructions
- stall  out  1  hold ID (combinational)
- sb_idle  out  1  no pending writes (registered)
- sb_err  out  1  sticky protocol error (registered)

## Operation
- State: 31 counters gpr_cnt[1..31] of CNT_W bits; x0 has no counter and is never busy. One csr_cnt of CNT_W bits.
- inc_gpr = id_fire & id_rd_wen & (id_rd != 0). dec_gpr = wb_valid & wb_rd_wen & (wb_rd != 0).
- inc_csr = id_fire & id_csr_wen. dec_csr = wb_valid & wb_csr_wen.
- Per counter per cycle: inc only → +1; dec only → −1; inc and dec on the same index → unchanged.
- busy(r) = gpr_cnt[r] != 0. csr_busy = csr_cnt != 0.
- stall = id_valid & ((id_rs1_used & busy(id_rs1)) | (id_rs2_used & busy(id_rs2)) | (id_csr_ren & csr_busy)). Reading x0 never stalls.
- flush: all counters → 0 next cycle. Same-cycle inc/dec are ignored.
- sb_err sets, and is cleared only by reset, on any of:
  - inc on a counter already at max (counter saturates, stays at max);
  - dec on a counter at 0 (counter stays 0);
  - id_fire while stall (the issue is still counted).
- sb_idle = 1 when all counters are 0 after the update.

## Timing
- Reset: all counters 0, sb_idle = 1, sb_err = 0. stall = 0 for any input while counters are 0.
- Issue at edge N → busy visible from cycle N+1.
- WB commit in cycle M (without bypass) → counter decrements at edge M; a dependent instruction is released in cycle M+1.
- stall has no registered latency. It must not depend on id_fire, so there is no combinational loop.
- flush together with reset: reset wins. Reset mid-operation discards all pending state.

## Configuration
- YSYX_22050499_SB_BYPASS_EN defined:
  - A source is not busy when its counter is 1 and WB is decrementing that same index this cycle, because the WB write data is forwarded to ID.
  - Same rule applies to CSRs.
  - The dependent instruction issues in cycle M.
- Undefined: no same-cycle release. stall uses register state only, giving a one-cycle extra bubble.

## Test plan
- Reset, then id_valid=1 with rs1=5 used → stall=0, sb_idle=1, sb_err=0.
- Issue rd=5 at edge 1. Next cycle ID reads rs1=5 → stall=1. WB commits rd=5 in cycle 4 → stall=0 in cycle 4 with bypass, cycle 5 without.
- Issue rd=7 twice, then commit rd=7 once → still busy (cnt=1). Second commit → cnt=0, sb_idle=1.
- Same-cycle issue rd=3 and commit rd=3 with cnt=1 → cnt stays 1, stall persists for rs2=3. Issue and read rd=0 → never stalls, no counter change.
- CSR: issue csr_wen, then ID presents csr_ren → stall=1 until the WB csr_wen commit.
- Overflow/underflow: 4 issues to rd=9 with CNT_W=2 → sb_err=1, cnt=3. After reset, commit rd=9 → sb_err=1. flush with pending writes → all counters 0 and sb_idle=1 next cycle.
